rr_arbiter_4req: RTL and testbench

//  Round-robin arbiter sharing one downstream port among 4 requesters (e.g. BHT/PHT

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick_4.sv | 30 +++
 rtl/rr_arbiter_4req.sv | 80 ++++++++
 tb/tb_rr_arbiter_4req.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-source round-robin arbiter.
// Holds the state encoding, sizes and the one-hot helper.
package arb_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } arb_state_e;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first set request at or after ptr.
// Rotates the request vector so a fixed priority encoder can be used.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [SEL_W-1:0]   o_idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    assign dbl = {i_req, i_req};
    assign rot = dbl[i_ptr +: NUM_REQ];

    // lowest set bit of the rotated vector is the offset from ptr
    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = SEL_W'(k);
        end
    end

    assign o_any = |i_req;
    assign o_idx = i_ptr + off;

endmodule

// File: rtl/rr_arbiter_4req.sv
// Round-robin arbiter: 4 requesters into one registered output entry.
// Grant pulses when a payload is captured; ptr moves past the winner.
module rr_arbiter_4req
    import arb_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [DATA_W-1:0]  i_data0,
    input  logic [DATA_W-1:0]  i_data1,
    input  logic [DATA_W-1:0]  i_data2,
    input  logic [DATA_W-1:0]  i_data3,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_valid,
    output logic [DATA_W-1:0]  o_data,
    input  logic               i_ready
);

    arb_state_e          state;
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    win;
    logic                any;
    logic                slot_free;
    logic [DATA_W-1:0]   win_data;

    rr_pick_4 u_pick (
        .i_req (i_req),
        .i_ptr (ptr),
        .o_any (any),
        .o_idx (win)
    );

    // payload mux steered by the picked index
    always_comb begin
        win_data = '0;
        unique case (win)
            2'd0: win_data = i_data0;
            2'd1: win_data = i_data1;
            2'd2: win_data = i_data2;
            2'd3: win_data = i_data3;
        endcase
    end

    assign slot_free = (state == S_IDLE) | (o_valid & i_ready);

    // output stage, state, rotation pointer and one-cycle grant pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
            o_grant <= '0;
        end else begin
            o_grant <= '0;
            if (i_flush) begin
                o_valid <= 1'b0;
                state   <= S_IDLE;
            end else if (slot_free) begin
                if (any) begin
                    o_data  <= win_data;
                    o_sel   <= win;
                    o_valid <= 1'b1;
                    o_grant <= onehot(win);
                    ptr     <= win + SEL_W'(1);
                    state   <= S_HOLD;
                end else begin
                    o_valid <= 1'b0;
                    state   <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// Self-checking bench for rr_arbiter_4req.
// Scoreboard of captured payloads plus directed and random scenarios.
module tb_rr_arbiter_4req;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_flush;
    logic       i_ready;
    logic [3:0] i_req;
    logic [1:0] d [4];
    logic [3:0] o_grant;
    logic [1:0] o_sel;
    logic       o_valid;
    logic [1:0] o_data;

    typedef struct packed {
        logic [1:0] idx;
        logic [1:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int n_chk = 0;
    int n_pass = 0;
    int m_ptr = 0;
    bit m_valid = 0;
    bit m_gexp = 0;
    int m_gidx = 0;

    rr_arbiter_4req #(.DATA_W(2)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_req   (i_req),
        .i_data0 (d[0]),
        .i_data1 (d[1]),
        .i_data2 (d[2]),
        .i_data3 (d[3]),
        .o_grant (o_grant),
        .o_sel   (o_sel),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready)
    );

    always #5 i_clk = ~i_clk;

    // reference model step: predict this edge, push capture, advance clock
    task automatic tick();
        int w;
        m_gexp = 0;
        if (i_flush) begin
            m_valid = 0;
        end else if (!m_valid || i_ready) begin
            if (i_req != 4'b0) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && i_req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                e.idx  = 2'(w);
                e.data = d[w];
                q.push_back(e);
                m_ptr   = (w + 1) % 4;
                m_valid = 1;
                m_gexp  = 1;
                m_gidx  = w;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_req   = 4'b0;
        i_flush = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        m_ptr   = 0;
        m_valid = 0;
        m_gexp  = 0;
        q.delete();
    endtask

    task automatic test_reset();
        n_chk++;
        if (o_valid !== 1'b0 || o_grant !== 4'b0 || o_sel !== 2'b0 || o_data !== 2'b0)
            $display("FAIL reset_init: v=%b g=%b s=%0d d=%b want 0", o_valid, o_grant, o_sel, o_data);
        else n_pass++;
        do_reset();
        i_ready = 1'b0;
        d[2]    = 2'b10;
        i_req   = 4'b0100;
        tick();
        n_chk++;
        if (o_valid !== 1'b1 || o_sel !== 2'd2 || o_data !== 2'b10)
            $display("FAIL reset_pre: v=%b s=%0d d=%b want 1 2 10", o_valid, o_sel, o_data);
        else n_pass++;
        #2;
        i_reset = 1'b1;
        #1;
        n_chk++;
        if (o_valid !== 1'b0 || o_grant !== 4'b0 || o_sel !== 2'b0)
            $display("FAIL reset_async: v=%b g=%b s=%0d want 0", o_valid, o_grant, o_sel);
        else n_pass++;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        m_ptr   = 0;
        m_valid = 0;
        q.delete();
        i_ready = 1'b1;
        i_req   = 4'b1111;
        tick();
        n_chk++;
        if (o_grant !== 4'b0001)
            $display("FAIL reset_ptr0: got %b want 0001", o_grant);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        d[0] = 2'b00; d[1] = 2'b01; d[2] = 2'b10; d[3] = 2'b11;
        i_ready = 1'b1;
        i_req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (o_grant !== exp_g[i] || o_valid !== 1'b1)
                $display("FAIL rr_grant%0d: got %b v=%b want %b v=1", i, o_grant, o_valid, exp_g[i]);
            else n_pass++;
            n_chk++;
            if (q.size() == 0) begin
                $display("FAIL rr_sb%0d: got grant %b want queued entry", i, o_grant);
            end else begin
                e = q.pop_front();
                if (o_data !== e.data || o_sel !== e.idx)
                    $display("FAIL rr_data%0d: got s=%0d d=%b want s=%0d d=%b", i, o_sel, o_data, e.idx, e.data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        i_ready = 1'b0;
        i_req   = 4'b1010;
        tick();
        n_chk++;
        if (o_grant !== 4'b0010 || o_sel !== 2'd1 || o_valid !== 1'b1)
            $display("FAIL hold_first: got g=%b s=%0d v=%b want 0010 1 1", o_grant, o_sel, o_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (o_grant !== 4'b0 || o_sel !== 2'd1 || o_valid !== 1'b1)
                $display("FAIL hold_stall%0d: got g=%b s=%0d v=%b want 0000 1 1", i, o_grant, o_sel, o_valid);
            else n_pass++;
        end
        i_ready = 1'b1;
        tick();
        n_chk++;
        if (o_grant !== 4'b1000 || o_sel !== 2'd3)
            $display("FAIL hold_next: got g=%b s=%0d want 1000 3", o_grant, o_sel);
        else n_pass++;
    endtask

    task automatic test_wrap_single();
        do_reset();
        i_ready = 1'b1;
        i_req   = 4'b0100;
        tick();
        i_req   = 4'b0001;
        tick();
        n_chk++;
        if (o_grant !== 4'b0001)
            $display("FAIL wrap_src0: got %b want 0001", o_grant);
        else n_pass++;
        i_req = 4'b1001;
        tick();
        n_chk++;
        if (o_grant !== 4'b1000)
            $display("FAIL wrap_src3: got %b want 1000", o_grant);
        else n_pass++;
        i_req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (o_grant !== 4'b0010 || o_valid !== 1'b1)
                $display("FAIL single%0d: got g=%b v=%b want 0010 1", i, o_grant, o_valid);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        do_reset();
        i_ready = 1'b0;
        i_req   = 4'b0001;
        tick();
        i_ready = 1'b1;
        i_flush = 1'b1;
        i_req   = 4'b0100;
        tick();
        n_chk++;
        if (o_valid !== 1'b0 || o_grant !== 4'b0)
            $display("FAIL flush_drop: got v=%b g=%b want 0 0000", o_valid, o_grant);
        else n_pass++;
        i_flush = 1'b0;
        tick();
        n_chk++;
        if (o_grant !== 4'b0100 || o_valid !== 1'b1 || o_sel !== 2'd2)
            $display("FAIL flush_after: got g=%b v=%b s=%0d want 0100 1 2", o_grant, o_valid, o_sel);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] pend;
        logic [3:0] snap;
        logic [3:0] exp_g;
        int wait_n [4];
        int max_wait = 0;
        int grants = 0;
        int acc = 0;
        int dropped = 0;
        int gi;
        do_reset();
        pend = 4'($urandom);
        for (int k = 0; k < 4; k++) begin
            d[k] = 2'($urandom);
            wait_n[k] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            i_req   = pend;
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 63) == 0);
            snap    = i_req;
            if (m_valid && i_flush) dropped++;
            else if (m_valid && i_ready) acc++;
            tick();
            exp_g = m_gexp ? (4'b0001 << m_gidx) : 4'b0000;
            n_chk++;
            if (o_grant !== exp_g || o_valid !== m_valid)
                $display("FAIL rnd_grant c%0d: got g=%b v=%b want %b v=%b", c, o_grant, o_valid, exp_g, m_valid);
            else n_pass++;
            if (o_grant !== 4'b0) begin
                grants++;
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_sb c%0d: got grant %b want queued entry", c, o_grant);
                end else begin
                    e = q.pop_front();
                    if (o_data !== e.data || o_sel !== e.idx)
                        $display("FAIL rnd_data c%0d: got s=%0d d=%b want s=%0d d=%b", c, o_sel, o_data, e.idx, e.data);
                    else n_pass++;
                end
                gi = m_gidx;
                for (int k = 0; k < 4; k++) begin
                    if (k == gi) begin
                        if (wait_n[k] > max_wait) max_wait = wait_n[k];
                        wait_n[k] = 0;
                    end else if (snap[k]) begin
                        wait_n[k]++;
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (o_grant[k]) begin
                    pend[k] = 1'($urandom_range(0, 1));
                    d[k]    = 2'($urandom);
                end else if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1'b1;
                    d[k]    = 2'($urandom);
                end
            end
        end
        n_chk++;
        if (q.size() != 0)
            $display("FAIL rnd_leftover: got %0d queued want 0", q.size());
        else n_pass++;
        n_chk++;
        if (grants != acc + dropped + int'(m_valid))
            $display("FAIL rnd_conserve: got %0d grants want %0d", grants, acc + dropped + int'(m_valid));
        else n_pass++;
        n_chk++;
        if (max_wait > 3)
            $display("FAIL rnd_fair: got max wait %0d want <= 3", max_wait);
        else n_pass++;
    endtask

    initial begin
        i_reset = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        i_req   = 4'b0;
        for (int k = 0; k < 4; k++) d[k] = 2'b0;
        #1;
        test_reset();
        test_round_robin();
        test_hold();
        test_wrap_single();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
